// File: rtl/wb_pkg.sv
// Shared definitions for the writeback commit buffer: default widths, occupancy
// encodings and the flag-register bit layout.
package wb_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 5;

    typedef enum logic [1:0] {
        CntEmpty = 2'd0,
        CntOne   = 2'd1,
        CntFull  = 2'd2
    } wb_cnt_e;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        logic [3:0] f;
        f        = '0;
        f[FlagN] = n;
        f[FlagZ] = z;
        f[FlagC] = c;
        f[FlagV] = v;
        return f;
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Two-entry forwarding lookup; the younger entry wins when both match, and
// register 0 never matches.
module wb_fwd_match #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              old_vld_i,
    input  logic [ADDR_W-1:0] old_dr_i,
    input  logic [DATA_W-1:0] old_data_i,
    input  logic              new_vld_i,
    input  logic [ADDR_W-1:0] new_dr_i,
    input  logic [DATA_W-1:0] new_data_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic addr_nz, old_hit, new_hit;

    always_comb begin
        addr_nz = addr_i != '0;
        old_hit = addr_nz & old_vld_i & (old_dr_i == addr_i);
        new_hit = addr_nz & new_vld_i & (new_dr_i == addr_i);
        hit_o   = old_hit | new_hit;
        data_o  = '0;
        if (new_hit) begin
            data_o = new_data_i;
        end else if (old_hit) begin
            data_o = old_data_i;
        end
    end

endmodule

// File: rtl/wb_commit_buffer.sv
// Two-entry writeback buffer between execute and the register-file write port;
// also owns the architectural NZCV flag register and a forwarding lookup.
module wb_commit_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              EX_VALID,
    output logic              EX_READY,
    input  logic [DATA_W-1:0] EX_Y,
    input  logic              EX_C,
    input  logic              EX_V,
    input  logic              EX_N,
    input  logic              EX_Z,
    input  logic [ADDR_W-1:0] EX_DR,
    input  logic              EX_WE,
    input  logic              EX_SETF,
    input  logic              RF_BUSY,
    output logic              LD,
    output logic [ADDR_W-1:0] DR,
    output logic [DATA_W-1:0] D_IN,
    output logic [3:0]        FLAGS,
    input  logic [ADDR_W-1:0] FWD_ADDR,
    output logic              FWD_HIT,
    output logic [DATA_W-1:0] FWD_DATA
);

    // Slot 0 is always the head; slot 1 is only occupied when full.
    wb_cnt_e           cnt_q, cnt_d;
    logic [DATA_W-1:0] y_q    [DEPTH];
    logic [DATA_W-1:0] y_d    [DEPTH];
    logic [ADDR_W-1:0] dr_q   [DEPTH];
    logic [ADDR_W-1:0] dr_d   [DEPTH];
    logic [3:0]        nzcv_q [DEPTH];
    logic [3:0]        nzcv_d [DEPTH];
    logic [DEPTH-1:0]  we_q, we_d, setf_q, setf_d;
    logic [3:0]        flags_q, flags_d;

    logic head_v, tail_v, push, pop, wr_idx;

    assign head_v   = cnt_q != CntEmpty;
    assign tail_v   = cnt_q == CntFull;
    assign EX_READY = RESET_N & (cnt_q != CntFull);
    assign push     = EX_VALID & EX_READY;
    assign pop      = head_v & ~RF_BUSY;
    // New entry lands behind whatever survives this edge.
    assign wr_idx   = (cnt_q == CntOne) & ~pop;

    assign LD    = RESET_N & head_v & we_q[0] & (dr_q[0] != '0) & ~RF_BUSY;
    assign DR    = dr_q[0];
    assign D_IN  = y_q[0];
    assign FLAGS = flags_q;

    always_comb begin
        cnt_d   = cnt_q;
        y_d     = y_q;
        dr_d    = dr_q;
        nzcv_d  = nzcv_q;
        we_d    = we_q;
        setf_d  = setf_q;
        flags_d = flags_q;

        if (pop) begin
            if (setf_q[0]) begin
                flags_d = nzcv_q[0];
            end
            // A lone retiring head is left in place so DR/D_IN hold their values.
            if (tail_v) begin
                y_d[0]    = y_q[1];
                dr_d[0]   = dr_q[1];
                nzcv_d[0] = nzcv_q[1];
                we_d[0]   = we_q[1];
                setf_d[0] = setf_q[1];
            end
        end

        if (push) begin
            y_d[wr_idx]    = EX_Y;
            dr_d[wr_idx]   = EX_DR;
            nzcv_d[wr_idx] = pack_nzcv(EX_N, EX_Z, EX_C, EX_V);
            we_d[wr_idx]   = EX_WE;
            setf_d[wr_idx] = EX_SETF;
        end

        unique case (cnt_q)
            CntEmpty: if (push) cnt_d = CntOne;
            CntOne: begin
                if (push && !pop) begin
                    cnt_d = CntFull;
                end else if (!push && pop) begin
                    cnt_d = CntEmpty;
                end
            end
            CntFull:  if (pop) cnt_d = CntOne;
            default:  cnt_d = CntEmpty;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt_q   <= CntEmpty;
            flags_q <= '0;
            we_q    <= '0;
            setf_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                y_q[i]    <= '0;
                dr_q[i]   <= '0;
                nzcv_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            we_q    <= we_d;
            setf_q  <= setf_d;
            y_q     <= y_d;
            dr_q    <= dr_d;
            nzcv_q  <= nzcv_d;
        end
    end

    wb_fwd_match #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd (
        .addr_i     (FWD_ADDR),
        .old_vld_i  (RESET_N & head_v & we_q[0]),
        .old_dr_i   (dr_q[0]),
        .old_data_i (y_q[0]),
        .new_vld_i  (RESET_N & tail_v & we_q[1]),
        .new_dr_i   (dr_q[1]),
        .new_data_i (y_q[1]),
        .hit_o      (FWD_HIT),
        .data_o     (FWD_DATA)
    );

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Scoreboard bench for wb_commit_buffer: accepted writes queue expected
// register-file writes, and a negedge monitor checks every LD pulse in order.
module tb_wb_commit_buffer;

    logic        CLK = 1'b0;
    logic        RESET_N, EX_VALID, EX_READY, EX_C, EX_V, EX_N, EX_Z, EX_WE, EX_SETF;
    logic        RF_BUSY, LD, FWD_HIT;
    logic [31:0] EX_Y, D_IN, FWD_DATA;
    logic [4:0]  EX_DR, DR, FWD_ADDR;
    logic [3:0]  FLAGS;

    typedef struct packed {
        logic [4:0]  dr;
        logic [31:0] y;
    } wr_t;

    wr_t sb[$];
    wr_t exp_w;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ld_cnt   = 0;
    int  l0;

    always #5 CLK = ~CLK;

    wb_commit_buffer #(
        .DATA_W (32),
        .ADDR_W (5),
        .DEPTH  (2)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .EX_VALID (EX_VALID),
        .EX_READY (EX_READY),
        .EX_Y     (EX_Y),
        .EX_C     (EX_C),
        .EX_V     (EX_V),
        .EX_N     (EX_N),
        .EX_Z     (EX_Z),
        .EX_DR    (EX_DR),
        .EX_WE    (EX_WE),
        .EX_SETF  (EX_SETF),
        .RF_BUSY  (RF_BUSY),
        .LD       (LD),
        .DR       (DR),
        .D_IN     (D_IN),
        .FLAGS    (FLAGS),
        .FWD_ADDR (FWD_ADDR),
        .FWD_HIT  (FWD_HIT),
        .FWD_DATA (FWD_DATA)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one result from just after a posedge; returns just after the accepting edge.
    task automatic accept(input logic [31:0] y, input logic [4:0] dr, input logic we,
                          input logic setf, input logic [3:0] nzcv);
        int waitc = 0;
        EX_VALID = 1'b1;
        EX_Y     = y;
        EX_DR    = dr;
        EX_WE    = we;
        EX_SETF  = setf;
        {EX_N, EX_Z, EX_C, EX_V} = nzcv;
        @(negedge CLK);
        while (!EX_READY && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        check("accept_ready", {63'd0, EX_READY}, 64'd1);
        if (EX_READY && we && dr != 5'd0) sb.push_back('{dr: dr, y: y});
        @(posedge CLK);
        #1;
        EX_VALID = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (LD) begin
            ld_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ld: got write DR=%0d D_IN=%0h, expected no write",
                         DR, D_IN);
            end else begin
                exp_w = sb.pop_front();
                check("ld_dr", {59'd0, DR}, {59'd0, exp_w.dr});
                check("ld_data", {32'd0, D_IN}, {32'd0, exp_w.y});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N  = 1'b0;
        EX_VALID = 1'b1;
        EX_Y     = 32'hDEAD_BEEF;
        EX_DR    = 5'd9;
        EX_WE    = 1'b1;
        EX_SETF  = 1'b1;
        {EX_N, EX_Z, EX_C, EX_V} = 4'hF;
        RF_BUSY  = 1'b0;
        FWD_ADDR = 5'd0;

        // Reset with a valid offered: nothing accepted, everything quiet.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", {63'd0, EX_READY}, 64'd0);
        check("rst_ld", {63'd0, LD}, 64'd0);
        check("rst_flags", {60'd0, FLAGS}, 64'd0);
        @(posedge CLK);
        #1;
        EX_VALID = 1'b0;
        RESET_N  = 1'b1;
        @(negedge CLK);
        check("rel_ready", {63'd0, EX_READY}, 64'd1);
        check("rel_dr", {59'd0, DR}, 64'd0);
        @(posedge CLK);
        #1;

        // Single write with C flag.
        accept(32'h0000_00FF, 5'd5, 1'b1, 1'b1, 4'b0010);
        @(negedge CLK);
        check("single_ld", {63'd0, LD}, 64'd1);
        @(posedge CLK);
        #1;
        check("single_flags", {60'd0, FLAGS}, 64'h2);
        check("single_ld_off", {63'd0, LD}, 64'd0);
        check("single_hold_dr", {59'd0, DR}, 64'd5);

        // x0 write is suppressed but still retires and sets flags.
        accept(32'h1234_5678, 5'd0, 1'b1, 1'b1, 4'b0100);
        @(negedge CLK);
        check("x0_ld", {63'd0, LD}, 64'd0);
        @(posedge CLK);
        #1;
        check("x0_flags", {60'd0, FLAGS}, 64'h4);

        // Backpressure: fill under RF_BUSY, third offer refused.
        RF_BUSY = 1'b1;
        accept(32'd1, 5'd1, 1'b1, 1'b1, 4'b1111);
        accept(32'd2, 5'd2, 1'b1, 1'b0, 4'b0000);
        EX_VALID = 1'b1;
        EX_DR    = 5'd3;
        @(negedge CLK);
        check("bp_ready_full", {63'd0, EX_READY}, 64'd0);
        check("bp_ld_busy", {63'd0, LD}, 64'd0);
        check("bp_flags_hold", {60'd0, FLAGS}, 64'h4);
        @(posedge CLK);
        #1;
        EX_VALID = 1'b0;
        RF_BUSY  = 1'b0;
        l0 = ld_cnt;
        @(negedge CLK);
        check("bp_ready_still_full", {63'd0, EX_READY}, 64'd0);
        @(posedge CLK);
        #1;
        check("bp_flags_first", {60'd0, FLAGS}, 64'hF);
        @(negedge CLK);
        check("bp_ready_back", {63'd0, EX_READY}, 64'd1);
        #1;
        check("bp_two_ld", ld_cnt - l0, 64'd2);
        @(posedge CLK);
        #1;
        check("bp_flags_keep", {60'd0, FLAGS}, 64'hF);
        check("bp_sb_empty", sb.size(), 64'd0);

        // Forwarding: youngest wins, x0 and non-matching addresses miss.
        RF_BUSY = 1'b1;
        accept(32'hA, 5'd7, 1'b1, 1'b0, 4'b0000);
        FWD_ADDR = 5'd7;
        #1;
        check("fwd_one_hit", {63'd0, FWD_HIT}, 64'd1);
        check("fwd_one_data", {32'd0, FWD_DATA}, 64'hA);
        accept(32'hB, 5'd7, 1'b1, 1'b0, 4'b0000);
        FWD_ADDR = 5'd7;
        #1;
        check("fwd_young_hit", {63'd0, FWD_HIT}, 64'd1);
        check("fwd_young_data", {32'd0, FWD_DATA}, 64'hB);
        FWD_ADDR = 5'd0;
        #1;
        check("fwd_x0_hit", {63'd0, FWD_HIT}, 64'd0);
        check("fwd_x0_data", {32'd0, FWD_DATA}, 64'd0);
        FWD_ADDR = 5'd3;
        #1;
        check("fwd_miss_hit", {63'd0, FWD_HIT}, 64'd0);
        check("fwd_miss_data", {32'd0, FWD_DATA}, 64'd0);
        RF_BUSY = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CLK);
        @(posedge CLK);
        #1;
        check("fwd_drained", sb.size(), 64'd0);
        FWD_ADDR = 5'd7;
        #1;
        check("fwd_empty_hit", {63'd0, FWD_HIT}, 64'd0);

        // Streaming: 8 back-to-back results, one LD per cycle.
        l0 = ld_cnt;
        for (int i = 0; i < 8; i++) begin
            accept(32'h100 + i, 5'(8 + i), 1'b1, 1'b1, 4'(i));
        end
        @(negedge CLK);
        #1;
        check("stream_ld_count", ld_cnt - l0, 64'd8);
        check("stream_sb_empty", sb.size(), 64'd0);
        @(posedge CLK);
        #1;
        check("stream_flags", {60'd0, FLAGS}, 64'h7);

        // Reset while full discards pending entries.
        RF_BUSY = 1'b1;
        accept(32'hC1, 5'd20, 1'b1, 1'b1, 4'hA);
        accept(32'hC2, 5'd21, 1'b1, 1'b1, 4'h5);
        EX_VALID = 1'b1;
        @(negedge CLK);
        check("mid_full", {63'd0, EX_READY}, 64'd0);
        @(posedge CLK);
        #1;
        EX_VALID = 1'b0;
        RESET_N  = 1'b0;
        RF_BUSY  = 1'b0;
        sb.delete();
        FWD_ADDR = 5'd20;
        @(negedge CLK);
        check("mid_rst_ld", {63'd0, LD}, 64'd0);
        check("mid_rst_ready", {63'd0, EX_READY}, 64'd0);
        check("mid_rst_fwd", {63'd0, FWD_HIT}, 64'd0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("mid_flags", {60'd0, FLAGS}, 64'd0);
        check("mid_ready", {63'd0, EX_READY}, 64'd1);
        check("mid_fwd", {63'd0, FWD_HIT}, 64'd0);
        check("mid_dr", {59'd0, DR}, 64'd0);
        check("mid_din", {32'd0, D_IN}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_buffer.md
Name: wb_commit_buffer

Overview:
- Writeback end of the execute datapath. Takes adder results (Y, C, V, N, Z) plus destination register from the execute stage through a valid/ready handshake.
- Buffers up to two results and drives the register-file write port (DR, D_IN, LD).
- Holds the architectural NZCV flag register.
- Provides a forwarding lookup so execute can read results not yet committed.

Parameters:
- DATA_W, 32, width of result word and D_IN
- ADDR_W, 5, register-file address width (DR, EX_DR, FWD_ADDR)
- DEPTH, 2, buffer entries; fixed at 2, other values unsupported

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RESET_N  input  1  synchronous active-low reset, sampled on CLK rising edge
- EX_VALID  input  1  execute stage presents a result this cycle
- EX_READY  output  1  buffer can accept; transfer when EX_VALID & EX_READY
- EX_Y  input  DATA_W  adder result
- EX_C, EX_V, EX_N, EX_Z  input  1 each  adder flags
- EX_DR  input  ADDR_W  destination register
- EX_WE  input  1  result is to be written to the register file
- EX_SETF  input  1  result updates the flag register
- RF_BUSY  input  1  register file cannot take a write this cycle
- LD  output  1  register-file write strobe
- DR  output  ADDR_W  write address (head entry)
- D_IN  output  DATA_W  write data (head entry)
- FLAGS  output  4  committed {N,Z,C,V}
- FWD_ADDR  input  ADDR_W  forwarding lookup address
- FWD_HIT  output  1  pending write to FWD_ADDR exists
- FWD_DATA  output  DATA_W  youngest pending data for FWD_ADDR; 0 when no hit

Behaviour:
- Storage is a 2-entry FIFO (head and tail slot) plus a count. States: EMPTY (0), ONE (1), FULL (2).
- Reset while RESET_N low at a rising edge: count=0, all entries invalid, FLAGS=4'b0000, DR=0, D_IN=0.
  - While RESET_N is low, LD=0, EX_READY=0 and FWD_HIT=0.
  - Reset mid-operation discards all pending entries; no write is issued.
- EX_READY = RESET_N & (count != 2). It is combinational from registered state and never depends on EX_VALID.
- Accept: EX_VALID & EX_READY at edge t. The entry {Y,C,V,N,Z,DR,WE,SETF} is stored at the tail.
- Head outputs: DR and D_IN always show the head entry when count>0 and hold their last values when EMPTY.
- LD = (count>0) & head.WE & (head.DR != 0) & ~RF_BUSY. Writes to x0 are suppressed.
- Retire: (count>0) & ~RF_BUSY at an edge pops the head. This applies even when LD=0 (WE=0 or DR=0).
  - If head.SETF, FLAGS <= {N,Z,C,V} of the head on the same edge.
- Latency: an entry accepted at edge t can drive LD in cycle t+1 at the earliest, giving 1-cycle accept-to-write.
- Throughput: with RF_BUSY=0 and EX_VALID held high, one result per cycle, steady in ONE.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept and retire -> ONE (old head out, new entry becomes head); accept only -> FULL; retire only -> EMPTY.
  - FULL: EX_READY=0; retire -> ONE.
- RF_BUSY held high: the head stays, LD=0, FLAGS unchanged, buffer fills to FULL and then backpressures.
- Forwarding: compare FWD_ADDR against valid entries with WE=1 and DR!=0.
  - If both hit, the tail (youngest) wins.
  - FWD_ADDR=0 never hits.
  - Purely combinational; it does not see the entry being accepted in the same cycle.
- Flags from entries with SETF=0 are discarded.

Decomposition:
- Shared package (wb_pkg): DATA_W/ADDR_W defaults, count encodings EMPTY/ONE/FULL, entry field layout and widths, flag bit positions N=3, Z=2, C=1, V=0.
- One natural sub-module: wb_fwd_match, the combinational 2-entry address compare with youngest-wins priority.
- FIFO control and flag register stay in the top block.

Test Plan:
- Reset: drive RESET_N=0 for 2 cycles with EX_VALID=1 -> EX_READY=0, LD=0, FLAGS=0. Release -> EX_READY=1, count EMPTY.
- Single write: accept Y=32'h0000_00FF, DR=5, WE=1, SETF=1, N=0, Z=0, C=1, V=0 with RF_BUSY=0 -> next cycle LD=1, DR=5, D_IN=32'h0000_00FF; after that edge FLAGS=4'b0010 and LD=0.
- x0 suppression: accept Y=32'h1234_5678, DR=0, WE=1, SETF=1, Z=1 -> LD never asserts, entry retires, FLAGS=4'b0100.
- Backpressure: RF_BUSY=1, accept DR=1 (Y=1) then DR=2 (Y=2) -> EX_READY=0 with a third offered. Drop RF_BUSY -> LD for DR=1 then DR=2 on consecutive cycles; EX_READY returns to 1 after the first retire.
- Forwarding: with RF_BUSY=1, pending DR=7 Y=32'hA then DR=7 Y=32'hB; FWD_ADDR=7 -> FWD_HIT=1, FWD_DATA=32'hB. FWD_ADDR=0 or 3 -> FWD_HIT=0, FWD_DATA=0.
- Streaming plus reset mid-run: 8 back-to-back results with RF_BUSY=0 -> 8 LD pulses in order at 1 per cycle. Assert RESET_N=0 while FULL -> no LD afterward, buffer EMPTY, FLAGS=0.
